// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: turns one RV32I load or store into a single request/response
// memory access, with lane steering, load extension, alignment checks and an access timeout.
module lsu_mem_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [2:0]            f3_q;
  logic                  we_q, err_q, err_d;
  logic [CntWidth-1:0]   cnt_q;
  logic                  req_illegal, req_misaligned, req_bad, tmo, accept;
  logic [DATA_WIDTH-1:0] shifted, load_fmt, lane_wdata;
  logic [3:0]            be_base;

  always_comb begin
    req_illegal = MemWrite ? (funct3[2] || (funct3[1:0] == 2'b11))
                           : ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    req_misaligned = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                     ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    req_bad = req_illegal || req_misaligned;
    accept  = (state_q == StIdle) && req_valid && !req_bad;
    // Fires on the TIMEOUT-th cycle spent in REQ/WAIT
    tmo     = (cnt_q == CntWidth'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; a handshake always takes priority over the timeout
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = req_bad ? StDone : StReq;
          err_d   = req_bad;
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d = we_q ? StDone : StWait;
          err_d   = 1'b0;
        end else if (tmo) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StDone;
          err_d   = 1'b0;
          rdata_d = load_fmt;
        end else if (tmo) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= ALUResult;
        wdata_q <= WriteData;
        f3_q    <= funct3;
        we_q    <= MemWrite;
        cnt_q   <= '0;
      end else if ((state_q == StReq) || (state_q == StWait)) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  // Lane steering for stores and extension for loads
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_fmt = {{(DATA_WIDTH - 8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{(DATA_WIDTH - 16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {{(DATA_WIDTH - 8){1'b0}}, shifted[7:0]};
      3'b101:  load_fmt = {{(DATA_WIDTH - 16){1'b0}}, shifted[15:0]};
      default: load_fmt = mem_rdata;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        be_base    = 4'b0001;
        lane_wdata = {(DATA_WIDTH / 8){wdata_q[7:0]}};
      end
      2'b01: begin
        be_base    = 4'b0011;
        lane_wdata = {(DATA_WIDTH / 16){wdata_q[15:0]}};
      end
      default: begin
        be_base    = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Outputs; memory-side signals are only driven while a request is outstanding
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    mem_wdata = mem_req ? lane_wdata : '0;
    mem_be    = mem_req ? (be_base << addr_q[1:0]) : 4'b0000;
    done      = (state_q == StDone);
    err       = done && err_q;
    stall     = rst_n && ((state_q == StReq) || (state_q == StWait) ||
                          ((state_q == StIdle) && req_valid));
    ReadData  = rdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a table of single accesses plus hand-written sequences
// for back-pressure, timeouts and reset in the middle of an access.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, MemWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUResult = '0, WriteData = '0;
  logic        stall, done, err, mem_req, mem_we;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  lsu_mem_master #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .stall(stall), .done(done),
    .ReadData(ReadData), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rdo;
    logic        er;
    int          cyc;
  } vec_t;

  typedef struct {
    bit          got_req;
    bit          stable;
    bit          timed_out;
    logic        stall_req;
    logic        mwe;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rdo;
    logic        erro;
    logic        busy_done;
    logic        done_after;
    int          cyc;
    int          nreq;
  } res_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One access; inputs change on the falling edge, outputs sampled there too
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int rdy_dly, input int rv_dly, output res_t r);
    bit acc;
    int nw;
    r = '{default: '0};
    r.timed_out = 1'b1;
    acc = 1'b0;
    nw = 0;
    @(negedge clk);
    req_valid = 1'b1; MemWrite = we; funct3 = f3; ALUResult = a; WriteData = wd;
    #1 r.stall_req = stall;
    r.cyc = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      r.cyc++;
      req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (done) begin
        r.timed_out = 1'b0;
        r.rdo = ReadData;
        r.erro = err;
        r.busy_done = mem_req || (mem_be != 4'b0000) || stall;
        break;
      end
      if (mem_req) begin
        if (!r.got_req) begin
          r.got_req = 1'b1; r.stable = 1'b1;
          r.be = mem_be; r.mwd = mem_wdata; r.maddr = mem_addr; r.mwe = mem_we;
        end else if (mem_be !== r.be || mem_wdata !== r.mwd || mem_addr !== r.maddr ||
                     mem_we !== r.mwe) begin
          r.stable = 1'b0;
        end
        if (r.nreq == rdy_dly) begin
          mem_ready = 1'b1;
          acc = 1'b1;
        end else begin
          mem_rvalid = 1'b1;  // stray response while still requesting
          mem_rdata = 32'hBAD0BAD0;
        end
        r.nreq++;
      end else if (acc) begin
        if (nw == rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd;
        end
        nw++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    r.done_after = done;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, " ReadData"}, ReadData, 32'd0);
  endtask

  vec_t tab[13];
  res_t r;

  initial begin
    tab[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 4};
    tab[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0, 4};
    tab[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 4'h8, 32'h0, 32'h00000080, 1'b0, 4};
    tab[3]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 4'hC, 32'h0, 32'hFFFF8001, 1'b0, 4};
    tab[4]  = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F234, 4'h3, 32'h0, 32'h0000F234, 1'b0, 4};
    tab[5]  = '{1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 4'h2, 32'h0, 32'h0000007F, 1'b0, 4};
    tab[6]  = '{1'b1, 3'b000, 32'h201, 32'h123456A5, 32'hFFFFFFFF, 4'h2, 32'hA5A5A5A5,
                32'h0000007F, 1'b0, 3};
    tab[7]  = '{1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 4'hF, 32'hCAFEF00D,
                32'h0000007F, 1'b0, 3};
    tab[8]  = '{1'b1, 3'b001, 32'h200, 32'h0000BEEF, 32'hFFFFFFFF, 4'h3, 32'hBEEFBEEF,
                32'h0000007F, 1'b0, 3};
    tab[9]  = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h11111111, 4'h0, 32'h0, 32'h0000007F, 1'b1, 2};
    tab[10] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h11111111, 4'h0, 32'h0, 32'h0000007F, 1'b1, 2};
    tab[11] = '{1'b1, 3'b100, 32'h100, 32'h0, 32'h11111111, 4'h0, 32'h0, 32'h0000007F, 1'b1, 2};
    tab[12] = '{1'b0, 3'b001, 32'h103, 32'h0, 32'h11111111, 4'h0, 32'h0, 32'h0000007F, 1'b1, 2};

    // Reset state, including a request held on the port while in reset
    #2 chk_all_zero("reset");
    req_valid = 1'b1;
    #1 chk("reset stall with req_valid", 32'(stall), 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      run(tab[i].we, tab[i].f3, tab[i].addr, tab[i].wd, tab[i].rd, 0, 0, r);
      chk($sformatf("v%0d timeout", i), 32'(r.timed_out), 32'd0);
      chk($sformatf("v%0d stall", i), 32'(r.stall_req), 32'd1);
      chk($sformatf("v%0d cycles", i), r.cyc, tab[i].cyc);
      chk($sformatf("v%0d mem_req seen", i), 32'(r.got_req), 32'(!tab[i].er));
      if (!tab[i].er) begin
        chk($sformatf("v%0d mem_be", i), 32'(r.be), 32'(tab[i].be));
        chk($sformatf("v%0d mem_we", i), 32'(r.mwe), 32'(tab[i].we));
        chk($sformatf("v%0d mem_addr", i), r.maddr, tab[i].addr & 32'hFFFFFFFC);
        if (tab[i].we) chk($sformatf("v%0d mem_wdata", i), r.mwd, tab[i].mwd);
      end
      chk($sformatf("v%0d ReadData", i), r.rdo, tab[i].rdo);
      chk($sformatf("v%0d err", i), 32'(r.erro), 32'(tab[i].er));
      chk($sformatf("v%0d idle outputs at done", i), 32'(r.busy_done), 32'd0);
      chk($sformatf("v%0d done one cycle", i), 32'(r.done_after), 32'd0);
    end

    // SH with ready delayed 3 cycles; accept lands on the timeout cycle and must win
    run(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 0, r);
    chk("sh_slow mem_be", 32'(r.be), 32'hC);
    chk("sh_slow mem_wdata", r.mwd, 32'hABCDABCD);
    chk("sh_slow stable", 32'(r.stable), 32'd1);
    chk("sh_slow req cycles", r.nreq, 4);
    chk("sh_slow cycles", r.cyc, 6);
    chk("sh_slow err", 32'(r.erro), 32'd0);
    chk("sh_slow ReadData", r.rdo, 32'h0000007F);

    // Memory never ready: abort after 4 cycles in REQ
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 99, 0, r);
    chk("tmo_req req cycles", r.nreq, 4);
    chk("tmo_req cycles", r.cyc, 6);
    chk("tmo_req err", 32'(r.erro), 32'd1);
    chk("tmo_req ReadData", r.rdo, 32'h0000007F);
    chk("tmo_req mem_req dropped", 32'(r.busy_done), 32'd0);

    // Accepted load whose data never arrives: REQ+WAIT budget runs out
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 99, r);
    chk("tmo_wait cycles", r.cyc, 6);
    chk("tmo_wait err", 32'(r.erro), 32'd1);
    chk("tmo_wait ReadData", r.rdo, 32'h0000007F);

    // Reset asserted in WAIT, then a late response after release
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("mid_reset in wait", 32'(stall && !mem_req && !done), 32'd1);
    rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("late_rvalid%0d done", k), 32'(done), 32'd0);
      chk($sformatf("late_rvalid%0d stall", k), 32'(stall), 32'd0);
      chk($sformatf("late_rvalid%0d ReadData", k), ReadData, 32'd0);
    end
    mem_rvalid = 1'b0;

    // Back in IDLE: a plain store still completes with minimum latency
    run(1'b1, 3'b010, 32'h400, 32'h01020304, 32'h0, 0, 0, r);
    chk("post_reset sw cycles", r.cyc, 3);
    chk("post_reset sw wdata", r.mwd, 32'h01020304);
    chk("post_reset sw err", 32'(r.erro), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data and address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent in REQ plus WAIT before an access is aborted.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL signal a load/store request from the core.
REQ-006 MemWrite  input  1  SHALL select a store (1) or a load (0).
REQ-007 funct3  input  3  SHALL carry the RV32I access size and signedness.
REQ-008 ALUResult  input  DATA_WIDTH  SHALL carry the byte address.
REQ-009 WriteData  input  DATA_WIDTH  SHALL carry the store data, right-aligned.
REQ-010 stall  output  1  SHALL hold the core pipeline.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 ReadData  output  DATA_WIDTH  SHALL carry the formatted, extended load result.
REQ-013 err  output  1  SHALL flag an aborted access; valid only with done.
REQ-014 mem_req  output  1  SHALL be the memory request valid.
REQ-015 mem_we  output  1  SHALL be the memory write enable.
REQ-016 mem_addr  output  DATA_WIDTH  SHALL be the word-aligned address, with bits [1:0] equal to 0.
REQ-017 mem_wdata  output  DATA_WIDTH  SHALL be the lane-positioned store data.
REQ-018 mem_be  output  4  SHALL carry the byte enables.
REQ-019 mem_ready  input  1  SHALL signal that the memory accepts the request.
REQ-020 mem_rvalid  input  1  SHALL signal that load data is valid.
REQ-021 mem_rdata  input  DATA_WIDTH  SHALL carry the raw load word.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-023 IDLE, req_valid=1, legal and aligned request: latch address, funct3, MemWrite and data; go to REQ.
REQ-024 IDLE, req_valid=1, illegal or misaligned request: go to DONE with err=1 and issue no memory access.
REQ-025 Misaligned SHALL mean a halfword with addr[0]=1, or a word with addr[1:0]!=0.
REQ-026 Illegal funct3 SHALL mean loads 011/110/111 and stores with funct3 other than 000/001/010.
REQ-027 stall SHALL equal (state!=IDLE && state!=DONE) || (state==IDLE && req_valid).
REQ-028 REQ: mem_req=1, with mem_addr/mem_we/mem_wdata/mem_be held stable until mem_ready=1.
REQ-029 REQ with mem_ready=1: a store SHALL go to DONE; a load SHALL go to WAIT.
REQ-030 WAIT with mem_rvalid=1: capture the formatted data into ReadData and go to DONE.
REQ-031 mem_rvalid SHALL be ignored in every state except WAIT.
REQ-032 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-033 A req_valid present during DONE SHALL be ignored; the core re-presents the request in IDLE.
REQ-034 Minimum latency from request to done SHALL be 2 cycles for a store and 3 cycles for a load.
REQ-035 Store byte enables: SB be = 4'b0001<<addr[1:0], with wdata byte replicated to all four lanes.
REQ-036 Store byte enables: SH be = 4'b0011<<addr[1:0], with wdata halfword replicated to both halves.
REQ-037 Store byte enables: SW be = 4'b1111.
REQ-038 mem_be SHALL be 0 whenever mem_req=0.
REQ-039 Load formatting SHALL select the lane by addr[1:0].
REQ-040 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word through.
REQ-041 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-042 When the counter reaches TIMEOUT: drop mem_req, go to DONE with err=1, leave ReadData unchanged.
REQ-043 If a timeout and a handshake occur in the same cycle, the handshake SHALL win and err=0.
REQ-044 ReadData SHALL hold its value until the next successful load completes.
REQ-045 err SHALL be 0 whenever done=0.

Reset
REQ-046 rst_n=0 SHALL immediately force state IDLE and counter 0.
REQ-047 rst_n=0 SHALL immediately force stall, done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_be and ReadData to 0.
REQ-048 Reset asserted mid-access SHALL abandon the access with no done pulse.
REQ-049 After reset, a late mem_rvalid SHALL be ignored.

Verification
REQ-050 LW addr 0x100, mem_ready=1 at once, mem_rvalid 2 cycles later with 0xDEADBEEF -> mem_be=1111, done in cycle 4, ReadData=0xDEADBEEF, err=0.
REQ-051 LB addr 0x103 with rdata 0x80FFFFFF -> ReadData=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-052 SH addr 0x202, WriteData 0x0000ABCD, mem_ready delayed 3 cycles -> mem_be=1100 and mem_wdata=0xABCDABCD held stable, done 1 cycle after accept.
REQ-053 LW addr 0x101 -> no mem_req, done+err next cycle; funct3=011 -> same response.
REQ-054 mem_ready never asserted with TIMEOUT=4 -> mem_req drops, done+err after 4 cycles in REQ, ReadData unchanged.
REQ-055 rst_n pulled low in WAIT, then mem_rvalid=1 after release -> all outputs 0, no done, state IDLE.
